seq_detector_param: RTL and testbench
=====================================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- SYM_W, 2: symbol width in bits.
- SEQ_LEN, 3: pattern length in symbols (>=2).
- CNT_W, 8: match counter width.
- DEF_PAT, 6'b11_10_01: reset pattern; symbol i occupies bits [i*SYM_W +: SYM_W], and symbol 0 is matched first.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: in_sym is presented this cycle.
- in_sym, in, SYM_W: input symbol.
- overlap_en, in, 1: 1 = overlapping matches allowed.
- pat_wr, in, 1: pattern write strobe.
- pat_idx, in, clog2(SEQ_LEN): pattern slot to write.
- pat_data, in, SYM_W: pattern symbol to write.
- clr_count, in, 1: synchronous clear of match_count.
- match, out, 1: registered one-cycle match pulse.
- fill, out, clog2(SEQ_LEN+1): number of valid symbols in the history window.
- match_count, out, CNT_W: saturating match total.

Function
REQ-003 The block SHALL keep a SEQ_LEN-deep symbol history window and a stored pattern register of SEQ_LEN*SYM_W bits.
REQ-004 On a clk edge with in_valid=1 and pat_wr=0, the window SHALL shift in in_sym, and fill SHALL increment, saturating at SEQ_LEN.
REQ-005 With in_valid=0, the window, fill and pattern SHALL hold, and match SHALL be 0 next cycle; idle cycles SHALL NOT break a partial sequence.
REQ-006 A hit SHALL occur when the post-shift window, oldest to newest, equals pattern symbols 0..SEQ_LEN-1 and the post-shift fill equals SEQ_LEN.
REQ-007 match SHALL be 1 for exactly the one cycle following the edge that accepted the completing symbol (latency 1), and 0 otherwise.
REQ-008 On a hit with overlap_en=1, fill SHALL stay at SEQ_LEN, so each further matching symbol can produce a back-to-back match.
REQ-009 On a hit with overlap_en=0, fill SHALL be forced to 0; symbols of the completed match SHALL NOT contribute to a later match.
REQ-010 overlap_en SHALL be sampled only on the hit edge.
REQ-011 Detection SHALL be exact substring matching: a mismatching symbol SHALL NOT discard valid suffixes, e.g. with the default pattern the stream 01,10,01,10,11 matches on the last symbol.
REQ-012 pat_wr=1 with pat_idx<SEQ_LEN SHALL write pat_data into slot pat_idx and SHALL clear fill to 0 on the same edge.
REQ-013 pat_wr=1 with pat_idx>=SEQ_LEN SHALL be ignored entirely, including the fill clear.
REQ-014 When pat_wr and in_valid are both 1, the write SHALL take precedence and in_sym SHALL be discarded, with no shift and no match.
REQ-015 match_count SHALL increment on every hit and saturate at 2^CNT_W-1.
REQ-016 When clr_count is 1, match_count SHALL become 0 on the next edge; clear SHALL win over a coincident hit, leaving the result 0.

Reset
REQ-017 On reset=1, asynchronously:
- match=0, fill=0, match_count=0;
- window cleared to all-zero;
- pattern loaded with DEF_PAT.
REQ-018 Reset asserted mid-sequence SHALL discard all partial progress; the first clk edge after deassertion SHALL behave as from power-up.

Configuration
REQ-019 With macro SEQDET_COUNT_EN defined, match_count and clr_count SHALL behave per REQ-015/016.
REQ-020 Without SEQDET_COUNT_EN, no counter flops SHALL be built, match_count SHALL be tied to 0, clr_count SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-021 Default pattern, stream 01,10,11 on consecutive cycles -> match=1 for the single cycle after the 11 edge, then 0, and match_count=1.
REQ-022 Pattern rewritten to 01,01,01, stream 01 x4 -> with overlap_en=1, matches after symbols 3 and 4; with overlap_en=0, match after symbol 3 only.
REQ-023 Default pattern, stream 01,10,01,10,11 with idle in_valid=0 gaps inserted -> exactly one match, after the final 11.
REQ-024 Default pattern, stream 01,10, then reset pulse, then 11 -> no match, fill=1 after the 11.
REQ-025 CNT_W=2 with SEQDET_COUNT_EN defined, five matches -> match_count saturates at 3; clr_count coincident with a match -> 0.
REQ-026 pat_wr with pat_idx=3 (SEQ_LEN=3) coincident with in_valid -> pattern and fill unchanged, symbol discarded.

Source files
------------

// File: rtl/seq_detector_param.sv
// Sliding-window symbol sequence detector with a writable pattern and a registered match pulse.
// Optional saturating match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int SYM_W   = 2,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 8,
  parameter logic [SEQ_LEN*SYM_W-1:0] DEF_PAT = 6'b11_10_01
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [SYM_W-1:0]             in_sym,
  input  logic                         overlap_en,
  input  logic                         pat_wr,
  input  logic [$clog2(SEQ_LEN)-1:0]   pat_idx,
  input  logic [SYM_W-1:0]             pat_data,
  input  logic                         clr_count,
  output logic                         match,
  output logic [$clog2(SEQ_LEN+1)-1:0] fill,
  output logic [CNT_W-1:0]             match_count
);

  localparam int PW     = SEQ_LEN * SYM_W;
  localparam int FILL_W = $clog2(SEQ_LEN + 1);

  // Window slot 0 holds the oldest symbol, so it lines up with pattern symbol 0.
  logic [PW-1:0]     r_win;
  logic [PW-1:0]     r_pat;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;

  logic              w_shift;
  logic              w_pat_ok;
  logic [PW-1:0]     w_win_next;
  logic              w_hit;

  // A write strobe always swallows the input symbol, even when its index is out of range.
  assign w_shift    = in_valid && !pat_wr;
  assign w_pat_ok   = pat_wr && (32'(pat_idx) < SEQ_LEN);
  assign w_win_next = {in_sym, r_win[PW-1:SYM_W]};
  assign w_hit      = w_shift && (r_fill >= FILL_W'(SEQ_LEN - 1)) && (w_win_next == r_pat);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win   <= '0;
      r_pat   <= DEF_PAT;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= w_hit;
      if (w_pat_ok) begin
        for (int i = 0; i < SEQ_LEN; i++) begin
          if (32'(pat_idx) == i) r_pat[i*SYM_W +: SYM_W] <= pat_data;
        end
        r_fill <= '0;
      end else if (w_shift) begin
        r_win <= w_win_next;
        if (w_hit && !overlap_en)
          r_fill <= '0;
        else if (r_fill < FILL_W'(SEQ_LEN))
          r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

  assign match = r_match;
  assign fill  = r_fill;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Clear beats a coincident hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (clr_count)
      r_count <= '0;
    else if (w_hit && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + CNT_W'(1);
  end

  assign match_count = r_count;
`else
  logic w_unused_clr;

  assign w_unused_clr = clr_count;
  assign match_count  = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default/overlap/non-overlap matching, gaps, pattern writes,
// reset mid-sequence and counter saturation/clear (counter expectations follow SEQDET_COUNT_EN).
module tb_seq_detector_param;

  localparam int SYM_W   = 2;
  localparam int SEQ_LEN = 3;
  localparam int CNT_W   = 2;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [SYM_W-1:0] in_sym;
  logic             overlap_en;
  logic             pat_wr;
  logic [1:0]       pat_idx;
  logic [SYM_W-1:0] pat_data;
  logic             clr_count;
  logic             match;
  logic [1:0]       fill;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(
    .SYM_W  (SYM_W),
    .SEQ_LEN(SEQ_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sym     (in_sym),
    .overlap_en (overlap_en),
    .pat_wr     (pat_wr),
    .pat_idx    (pat_idx),
    .pat_data   (pat_data),
    .clr_count  (clr_count),
    .match      (match),
    .fill       (fill),
    .match_count(match_count)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, need done)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt_exp(input int n);
`ifdef SEQDET_COUNT_EN
    return (n > 3) ? 3 : n;
`else
    return 0 * n;
`endif
  endfunction

  // driver tasks: inputs change at negedge, outputs sampled 1ns after posedge
  task automatic send(input logic [1:0] sym);
    @(negedge clk);
    in_valid = 1'b1;
    in_sym   = sym;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_pat(input logic [1:0] idx, input logic [1:0] data,
                        input logic vld, input logic [1:0] sym);
    @(negedge clk);
    pat_wr   = 1'b1;
    pat_idx  = idx;
    pat_data = data;
    in_valid = vld;
    in_sym   = sym;
    @(posedge clk);
    #1;
    pat_wr   = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [1:0] sym, input int m, input int f);
    send(sym);
    check({tag, "_match"}, int'(match), m);
    check({tag, "_fill"}, int'(fill), f);
  endtask

  initial begin
    in_valid = 0; in_sym = 0; overlap_en = 0; pat_wr = 0;
    pat_idx = 0; pat_data = 0; clr_count = 0;
    reset = 1'b1;
    #12;
    check("rst_match", int'(match), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_count", int'(match_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // default pattern 01,10,11, non-overlapping
    send_chk("def1", 2'b01, 0, 1);
    send_chk("def2", 2'b10, 0, 2);
    send_chk("def3", 2'b11, 1, 0);
    idle();
    check("def_pulse_end", int'(match), 0);
    check("def_count", int'(match_count), cnt_exp(1));

    // suffix retention with idle gaps
    send_chk("gap1", 2'b01, 0, 1);
    idle(); check("gap_idle1", int'(match), 0);
    send_chk("gap2", 2'b10, 0, 2);
    idle();
    send_chk("gap3", 2'b01, 0, 3);
    idle(); check("gap_hold_fill", int'(fill), 3);
    send_chk("gap4", 2'b10, 0, 3);
    idle();
    send_chk("gap5", 2'b11, 1, 0);
    check("gap_count", int'(match_count), cnt_exp(2));

    // pattern 01,01,01 with overlap
    wr_pat(2'd0, 2'b01, 1'b0, 2'b00);
    wr_pat(2'd1, 2'b01, 1'b0, 2'b00);
    wr_pat(2'd2, 2'b01, 1'b0, 2'b00);
    check("wr_fill", int'(fill), 0);
    overlap_en = 1'b1;
    send_chk("ovl1", 2'b01, 0, 1);
    send_chk("ovl2", 2'b01, 0, 2);
    send_chk("ovl3", 2'b01, 1, 3);
    send_chk("ovl4", 2'b01, 1, 3);
    check("ovl_count", int'(match_count), cnt_exp(4));

    // same stream without overlap; valid-index write with in_valid clears fill and drops symbol
    wr_pat(2'd0, 2'b01, 1'b1, 2'b01);
    check("wrv_match", int'(match), 0);
    check("wrv_fill", int'(fill), 0);
    overlap_en = 1'b0;
    send_chk("nov1", 2'b01, 0, 1);
    send_chk("nov2", 2'b01, 0, 2);
    send_chk("nov3", 2'b01, 1, 0);
    send_chk("nov4", 2'b01, 0, 1);
    check("sat_count", int'(match_count), cnt_exp(5));

    // out-of-range write coincident with in_valid: ignored, symbol discarded
    wr_pat(2'd3, 2'b10, 1'b1, 2'b01);
    check("oob_match", int'(match), 0);
    check("oob_fill", int'(fill), 1);
    send_chk("oob1", 2'b01, 0, 2);
    send_chk("oob2", 2'b01, 1, 0);

    // clear coincident with a hit
    send_chk("clr1", 2'b01, 0, 1);
    send_chk("clr2", 2'b01, 0, 2);
    @(negedge clk);
    clr_count = 1'b1;
    send_chk("clr3", 2'b01, 1, 0);
    check("clr_count", int'(match_count), 0);

    // reset mid-sequence restores default pattern and discards progress
    send_chk("rmid1", 2'b01, 0, 1);
    send_chk("rmid2", 2'b10, 0, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rmid_async_fill", int'(fill), 0);
    @(negedge clk);
    reset = 1'b0;
    send_chk("rmid3", 2'b11, 0, 1);
    send_chk("rmid4", 2'b01, 0, 2);
    send_chk("rmid5", 2'b10, 0, 3);
    send_chk("rmid6", 2'b11, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
